// File: rtl/seg_scan_driver.sv
// Time-multiplexed eight-digit seven-segment scan driver with per-frame coherent pattern capture.
// Optional inter-digit blanking is compiled in with `define SEG_SCAN_BLANK_EN.
module seg_scan_driver #(
  parameter int unsigned DWELL          = 4,
  parameter int unsigned BLANK_CYC      = 1,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [6:0] n_msb,
  input  logic [6:0] n_lsb,
  input  logic [6:0] e_msb,
  input  logic [6:0] e_lsb,
  input  logic [6:0] s_msb,
  input  logic [6:0] s_lsb,
  input  logic [6:0] w_msb,
  input  logic [6:0] w_lsb,
  output logic [6:0] seg_out,
  output logic [7:0] an_out,
  output logic [2:0] digit_idx,
  output logic       frame_done
);

  localparam int unsigned CntMax = (DWELL > BLANK_CYC) ? DWELL : BLANK_CYC;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] DwellLast = CntW'(DWELL - 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StShow  = 2'd1;
`ifdef SEG_SCAN_BLANK_EN
  localparam logic [1:0] StBlank = 2'd2;
  localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYC - 1);
`endif

  logic [1:0]      state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            reload;
  logic [6:0]      pat [8];
  logic [6:0]      shadow_q [8];
  logic [6:0]      shadow_d [8];
  logic [6:0]      seg_d;
  logic [7:0]      an_d;
  logic            frame_done_d;

  assign pat[0] = n_msb;
  assign pat[1] = n_lsb;
  assign pat[2] = e_msb;
  assign pat[3] = e_lsb;
  assign pat[4] = s_msb;
  assign pat[5] = s_lsb;
  assign pat[6] = w_msb;
  assign pat[7] = w_lsb;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    reload  = 1'b0;
    case (state_q)
      StIdle: begin
        if (en) begin
          state_d = StShow;
          idx_d   = 3'd0;
          cnt_d   = '0;
          reload  = 1'b1;
        end
      end
      StShow: begin
        if (cnt_q == DwellLast) begin
          cnt_d = '0;
`ifdef SEG_SCAN_BLANK_EN
          state_d = StBlank;
`else
          idx_d  = idx_q + 3'd1;
          reload = (idx_q == 3'd7);
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef SEG_SCAN_BLANK_EN
      StBlank: begin
        if (cnt_q == BlankLast) begin
          cnt_d   = '0;
          state_d = StShow;
          idx_d   = idx_q + 3'd1;
          reload  = (idx_q == 3'd7);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`endif
      default: begin
        state_d = StIdle;
        idx_d   = 3'd0;
        cnt_d   = '0;
      end
    endcase
    // Dropping enable overrides any wrap or reload on the same edge.
    if (!en) begin
      state_d = StIdle;
      idx_d   = 3'd0;
      cnt_d   = '0;
      reload  = 1'b0;
    end
  end

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      shadow_d[i] = reload ? pat[i] : shadow_q[i];
    end
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    seg_d = 7'h00;
    an_d  = 8'h00;
    if (state_d == StShow) begin
      seg_d = shadow_d[idx_d];
      an_d  = 8'h01 << idx_d;
    end
`ifdef SEG_SCAN_BLANK_EN
    frame_done_d = (state_d == StBlank) && (idx_d == 3'd7) && (cnt_d == BlankLast);
`else
    frame_done_d = (state_d == StShow) && (idx_d == 3'd7) && (cnt_d == DwellLast);
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      idx_q      <= 3'd0;
      cnt_q      <= '0;
      for (int i = 0; i < 8; i++) begin
        shadow_q[i] <= 7'h00;
      end
      seg_out    <= {7{SEG_ACTIVE_LOW}};
      an_out     <= {8{AN_ACTIVE_LOW}};
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cnt_q      <= cnt_d;
      for (int i = 0; i < 8; i++) begin
        shadow_q[i] <= shadow_d[i];
      end
      seg_out    <= seg_d ^ {7{SEG_ACTIVE_LOW}};
      an_out     <= an_d ^ {8{AN_ACTIVE_LOW}};
      frame_done <= frame_done_d;
    end
  end

  assign digit_idx = idx_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver: timeline model plus directed literal checks.
module tb_seg_scan_driver;
  localparam int DWELL     = 4;
  localparam int BLANK_CYC = 2;
`ifdef SEG_SCAN_BLANK_EN
  localparam int P = DWELL + BLANK_CYC;
`else
  localparam int P = DWELL;
`endif
  localparam int F = 8 * P;

  logic       clk   = 1'b0;
  logic       reset = 1'b0;
  logic       en    = 1'b0;
  logic [6:0] pin [8];
  logic [6:0] seg_out;
  logic [7:0] an_out;
  logic [2:0] digit_idx;
  logic       frame_done;

  int n_cmp = 0;
  int n_err = 0;

  seg_scan_driver #(
    .DWELL         (DWELL),
    .BLANK_CYC     (BLANK_CYC),
    .SEG_ACTIVE_LOW(1'b0),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .n_msb     (pin[0]),
    .n_lsb     (pin[1]),
    .e_msb     (pin[2]),
    .e_lsb     (pin[3]),
    .s_msb     (pin[4]),
    .s_lsb     (pin[5]),
    .w_msb     (pin[6]),
    .w_lsb     (pin[7]),
    .seg_out   (seg_out),
    .an_out    (an_out),
    .digit_idx (digit_idx),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: cycles elapsed since scan start, and the patterns captured for the current frame.
  bit         active = 1'b0;
  int         t = 0;
  logic [6:0] snap [8];

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      active <= 1'b0;
    end else if (!en) begin
      active <= 1'b0;
    end else if (!active) begin
      active <= 1'b1;
      t      <= 0;
      for (int i = 0; i < 8; i++) snap[i] <= pin[i];
    end else begin
      t <= t + 1;
      if ((t + 1) % F == 0) for (int i = 0; i < 8; i++) snap[i] <= pin[i];
    end
  end

  always @(negedge clk) begin : cmp
    int         d;
    bit         lit;
    logic [6:0] seg_e;
    logic [7:0] an_e;
    logic       fd_e;
    d     = active ? (t / P) % 8 : 0;
    lit   = active && ((t % P) < DWELL);
    seg_e = lit ? snap[d] : 7'h00;
    an_e  = lit ? ~(8'h01 << d) : 8'hFF;
    fd_e  = active && ((t % F) == F - 1);
    check("model_seg", 32'(seg_out), 32'(seg_e));
    check("model_an", 32'(an_out), 32'(an_e));
    check("model_idx", 32'(digit_idx), 32'(d));
    check("model_frame_done", 32'(frame_done), 32'(fd_e));
    check("one_hot", 32'($countones(~an_out) <= 1), 32'd1);
  end

  task automatic lit_chk(input string name, input logic [7:0] an_e, input logic [6:0] seg_e,
                         input logic [2:0] idx_e, input logic fd_e);
    check({name, "_an"}, 32'(an_out), 32'(an_e));
    check({name, "_seg"}, 32'(seg_out), 32'(seg_e));
    check({name, "_idx"}, 32'(digit_idx), 32'(idx_e));
    check({name, "_fd"}, 32'(frame_done), 32'(fd_e));
  endtask

  // Waits (bounded) for a lit digit idx, or for frame_done when fd is set.
  task automatic wait_for(input string name, input int idx, input bit fd);
    int k;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (fd ? (frame_done === 1'b1) : (digit_idx == 3'(idx) && an_out != 8'hFF)) break;
    end
    check(name, 32'(k < 400), 32'd1);
  endtask

  initial begin
    pin = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h40, 7'h7F};
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c % 5 == 0) lit_chk("idle", 8'hFF, 7'h00, 3'd0, 1'b0);
    end

    en = 1'b1;
    for (int c = 1; c <= 2 * F + 1; c++) begin
      @(negedge clk);
`ifdef SEG_SCAN_BLANK_EN
      case (c)
        1:  lit_chk("scan_c1", 8'hFE, 7'h01, 3'd0, 1'b0);
        5:  lit_chk("scan_blank0", 8'hFF, 7'h00, 3'd0, 1'b0);
        7:  lit_chk("scan_c7", 8'hFD, 7'h02, 3'd1, 1'b0);
        43: lit_chk("scan_c43", 8'h7F, 7'h7F, 3'd7, 1'b0);
        47: lit_chk("scan_c47", 8'hFF, 7'h00, 3'd7, 1'b0);
        48: lit_chk("scan_c48", 8'hFF, 7'h00, 3'd7, 1'b1);
        49: lit_chk("scan_c49", 8'hFE, 7'h01, 3'd0, 1'b0);
        96: lit_chk("scan_c96", 8'hFF, 7'h00, 3'd7, 1'b1);
        default: ;
      endcase
`else
      case (c)
        1:  lit_chk("scan_c1", 8'hFE, 7'h01, 3'd0, 1'b0);
        5:  lit_chk("scan_c5", 8'hFD, 7'h02, 3'd1, 1'b0);
        17: lit_chk("scan_c17", 8'hEF, 7'h10, 3'd4, 1'b0);
        31: lit_chk("scan_c31", 8'h7F, 7'h7F, 3'd7, 1'b0);
        32: lit_chk("scan_c32", 8'h7F, 7'h7F, 3'd7, 1'b1);
        33: lit_chk("scan_c33", 8'hFE, 7'h01, 3'd0, 1'b0);
        64: lit_chk("scan_c64", 8'h7F, 7'h7F, 3'd7, 1'b1);
        default: ;
      endcase
`endif
    end

    // Frame coherence: mid-frame change is deferred to the next frame.
    wait_for("wait_idx3", 3, 1'b0);
    pin[0] = 7'h3F;
    wait_for("wait_frame_done", 0, 1'b1);
    @(negedge clk);
    lit_chk("coherent_new", 8'hFE, 7'h3F, 3'd0, 1'b0);

    // Enable abort and restart with freshly sampled inputs.
    wait_for("wait_idx5", 5, 1'b0);
    en = 1'b0;
    @(negedge clk);
    lit_chk("abort", 8'hFF, 7'h00, 3'd0, 1'b0);
    pin[0] = 7'h55;
    @(negedge clk);
    lit_chk("abort_idle", 8'hFF, 7'h00, 3'd0, 1'b0);
    en = 1'b1;
    @(negedge clk);
    lit_chk("restart", 8'hFE, 7'h55, 3'd0, 1'b0);

    // Asynchronous reset between clock edges.
    wait_for("wait_idx6", 6, 1'b0);
    #3 reset = 1'b0;
    #1 lit_chk("async_reset", 8'hFF, 7'h00, 3'd0, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    lit_chk("post_reset", 8'hFE, 7'h55, 3'd0, 1'b0);

    repeat (F + 5) @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
